// File: rtl/nkmd_dai_rx.sv
// DAI receive buffer: 64x24 ring of received samples exposed to the NKMD CPU
// as an unread count, a sticky overflow flag and a 64-word read window.
module nkmd_dai_rx #(
   parameter logic [31:0] ADDR_CSR  = 32'h0000d001,
   parameter logic [31:0] ADDR_STAT = 32'h0000d002,
   parameter logic [31:0] ADDR_BUF  = 32'h0000e000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        rx_ack_i,
   input  logic [23:0] rx_data_i,
   input  logic [31:0] data_i,
   output logic [31:0] data_o,
   input  logic [31:0] addr_i,
   input  logic        we_i,
   output logic        rx_overflow_o
);

   logic [23:0] ring [64];
   logic [5:0]  wr_ff;
   logic [5:0]  rd_ff;
   logic [5:0]  unread_ff;
   logic        overflow_ff;

   logic        full;
   logic        push;
   logic        drop;
   logic        csr_we;
   logic        stat_clr;
   logic [5:0]  n_cons;
   logic [31:0] buf_off;
   logic [5:0]  rd_idx;
   logic [31:0] rd_next;
   logic        unused_ok;

   assign unused_ok = ^data_i[31:6];

   always_comb begin
      full     = (unread_ff == 6'd63);
      push     = rx_ack_i & ~full;
      drop     = rx_ack_i & full;
      csr_we   = we_i & (addr_i == ADDR_CSR);
      stat_clr = we_i & (addr_i == ADDR_STAT) & data_i[0];
      n_cons   = 6'd0;
      if (csr_we)
         n_cons = (data_i[5:0] < unread_ff) ? data_i[5:0] : unread_ff;
      buf_off  = addr_i - ADDR_BUF;
      rd_idx   = rd_ff + buf_off[5:0];
      rd_next  = 32'h0;
      if (addr_i == ADDR_CSR)
         rd_next = {26'h0, unread_ff};
      else if (addr_i == ADDR_STAT)
         rd_next = {31'h0, overflow_ff};
      else if (buf_off[31:6] == 26'h0)
         rd_next = {8'h0, ring[rd_idx]};
   end

   // count is computed against the pre-push value so a same-cycle
   // consume can never eat the sample arriving this cycle
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ff       <= 6'd0;
         rd_ff       <= 6'd0;
         unread_ff   <= 6'd0;
         overflow_ff <= 1'b0;
         data_o      <= 32'h0;
      end else begin
         if (push)
            wr_ff <= wr_ff + 6'd1;
         rd_ff     <= rd_ff + n_cons;
         unread_ff <= unread_ff + {5'd0, push} - n_cons;
         if (drop)
            overflow_ff <= 1'b1;
         else if (stat_clr)
            overflow_ff <= 1'b0;
         data_o <= rd_next;
      end
   end

   always_ff @(posedge clk) begin
      if (push && rst)
         ring[wr_ff] <= rx_data_i;
   end

   assign rx_overflow_o = overflow_ff;

endmodule

// File: tb/tb_nkmd_dai_rx.sv
// Bench for nkmd_dai_rx: counter-based sample model checked every cycle,
// plus literal expectations on the directed scenarios.
module tb_nkmd_dai_rx;

   localparam logic [31:0] CSR  = 32'h0000d001;
   localparam logic [31:0] STAT = 32'h0000d002;
   localparam logic [31:0] BUF  = 32'h0000e000;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        rx_ack_i = 1'b0;
   logic [23:0] rx_data_i = 24'h0;
   logic [31:0] data_i = 32'h0;
   logic [31:0] addr_i = 32'h0;
   logic        we_i = 1'b0;
   wire  [31:0] data_o;
   wire         rx_overflow_o;

   int checks = 0;
   int errors = 0;

   nkmd_dai_rx #(
      .ADDR_CSR (CSR),
      .ADDR_STAT(STAT),
      .ADDR_BUF (BUF)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .rx_ack_i     (rx_ack_i),
      .rx_data_i    (rx_data_i),
      .data_i       (data_i),
      .data_o       (data_o),
      .addr_i       (addr_i),
      .we_i         (we_i),
      .rx_overflow_o(rx_overflow_o)
   );

   always #5 clk = ~clk;

   // model: totals of accepted and consumed samples since reset
   int          m_push;
   int          m_cons;
   logic        m_ovf;
   logic [23:0] m_mem [64];
   bit          m_val [64];
   logic [31:0] exp_d;
   bit          exp_known;

   function automatic int m_cnt();
      return m_push - m_cons;
   endfunction

   function automatic bit m_acc();
      return rx_ack_i && (m_cnt() < 63);
   endfunction

   function automatic int m_n();
      int req;
      req = int'(data_i[5:0]);
      if (we_i && addr_i == CSR)
         return (req < m_cnt()) ? req : m_cnt();
      return 0;
   endfunction

   function automatic logic m_ovf_next();
      if (rx_ack_i && m_cnt() == 63)
         return 1'b1;
      if (we_i && addr_i == STAT && data_i[0])
         return 1'b0;
      return m_ovf;
   endfunction

   function automatic int m_slot(input int k);
      return (m_cons + k) % 64;
   endfunction

   function automatic logic [31:0] m_read();
      logic [31:0] k;
      k = addr_i - BUF;
      if (addr_i == CSR)
         return 32'(m_cnt());
      if (addr_i == STAT)
         return {31'h0, m_ovf};
      if (k < 64)
         return {8'h0, m_mem[m_slot(int'(k))]};
      return 32'h0;
   endfunction

   function automatic bit m_known();
      logic [31:0] k;
      k = addr_i - BUF;
      if (addr_i != CSR && addr_i != STAT && k < 64)
         return m_val[m_slot(int'(k))];
      return 1'b1;
   endfunction

   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         m_push    <= 0;
         m_cons    <= 0;
         m_ovf     <= 1'b0;
         exp_d     <= 32'h0;
         exp_known <= 1'b1;
      end else begin
         m_push    <= m_push + (m_acc() ? 1 : 0);
         m_cons    <= m_cons + m_n();
         m_ovf     <= m_ovf_next();
         exp_d     <= m_read();
         exp_known <= m_known();
      end
   end

   always @(posedge clk) begin
      if (rst && m_acc()) begin
         m_mem[m_push % 64] <= rx_data_i;
         m_val[m_push % 64] <= 1'b1;
      end
   end

   // compare process: model every cycle plus any pending literal check
   logic        lit_req = 1'b0;
   logic        lit_ov = 1'b0;
   logic [31:0] lit_exp = 32'h0;
   string       lit_name = "";

   wire [31:0] lit_got = lit_ov ? {31'h0, rx_overflow_o} : data_o;
   wire bad_d = exp_known && (data_o !== exp_d);
   wire bad_o = (rx_overflow_o !== m_ovf);
   wire bad_l = lit_req && (lit_got !== lit_exp);

   always @(negedge clk) begin
      checks <= checks + 1 + int'(exp_known) + int'(lit_req);
      errors <= errors + int'(bad_d) + int'(bad_o) + int'(bad_l);
      if (bad_d)
         $display("FAIL model_data t=%0t got=%h exp=%h", $time, data_o, exp_d);
      if (bad_o)
         $display("FAIL model_ovf t=%0t got=%b exp=%b", $time, rx_overflow_o, m_ovf);
      if (bad_l)
         $display("FAIL %s t=%0t got=%h exp=%h", lit_name, $time, lit_got, lit_exp);
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic cyc(input logic ack, input logic [23:0] rd,
                      input logic we, input logic [31:0] a,
                      input logic [31:0] d);
      rx_ack_i  = ack;
      rx_data_i = rd;
      we_i      = we;
      addr_i    = a;
      data_i    = d;
      tick();
      rx_ack_i  = 1'b0;
      we_i      = 1'b0;
   endtask

   task automatic push(input logic [23:0] v);
      cyc(1'b1, v, 1'b0, addr_i, 32'h0);
   endtask

   task automatic wr(input logic [31:0] a, input logic [31:0] d);
      cyc(1'b0, 24'h0, 1'b1, a, d);
   endtask

   task automatic rd(input logic [31:0] a);
      cyc(1'b0, 24'h0, 1'b0, a, 32'h0);
   endtask

   task automatic chk(input string nm, input logic [31:0] e, input logic ov);
      lit_name = nm;
      lit_exp  = e;
      lit_ov   = ov;
      lit_req  = 1'b1;
      @(negedge clk);
      #1;
      lit_req  = 1'b0;
   endtask

   task automatic rdchk(input string nm, input logic [31:0] a,
                        input logic [31:0] e);
      rd(a);
      chk(nm, e, 1'b0);
   endtask

   initial begin
      #2 rst = 1'b0;
      repeat (2) @(negedge clk);
      #1 rst = 1'b1;

      rdchk("reset_csr", CSR, 32'h0);
      chk("reset_ovf", 32'h0, 1'b1 == 1'b0);

      push(24'hcafebb);
      rdchk("first_sample", BUF, 32'h00cafebb);
      rdchk("count_one", CSR, 32'h1);
      wr(CSR, 32'h1);
      rdchk("consume_one", CSR, 32'h0);

      for (int v = 0; v < 63; v++)
         push(24'(v));
      rdchk("count_full", CSR, 32'd63);
      push(24'h3f);
      chk("ovf_set", 32'h1, 1'b1);
      rdchk("oldest_62", BUF + 32'd62, 32'h3e);
      rdchk("stat_set", STAT, 32'h1);
      wr(STAT, 32'h1);
      chk("ovf_clr", 32'h0, 1'b1);

      wr(CSR, 32'd63);
      rdchk("drained", CSR, 32'h0);
      for (int v = 63; v < 80; v++)
         push(24'(v));
      for (int k = 0; k < 17; k++)
         rdchk("wrap_window", BUF + 32'(k), 32'(63 + k));
      wr(BUF, 32'hffffff);
      rdchk("buf_write_ignored", BUF, 32'd63);
      rdchk("unmapped", 32'h00001234, 32'h0);
      wr(CSR, 32'd100);
      rdchk("consume_clamp", CSR, 32'h0);

      for (int v = 0; v < 5; v++)
         push(24'h100 + 24'(v));
      cyc(1'b1, 24'habc, 1'b1, CSR, 32'h2);
      rdchk("push_consume_cnt", CSR, 32'd4);
      rdchk("push_consume_pos", BUF + 32'd3, 32'h00000abc);
      rdchk("push_consume_old", BUF, 32'h00000102);

      for (int v = 0; v < 59; v++)
         push(24'h200 + 24'(v));
      rd(BUF + 32'd63);
      cyc(1'b1, 24'h777, 1'b1, STAT, 32'h1);
      chk("drop_beats_clear", 32'h1, 1'b1);
      wr(STAT, 32'h1);
      rdchk("stat_cleared", STAT, 32'h0);

      wr(CSR, 32'd63);
      push(24'h11);
      push(24'h22);
      push(24'h33);
      rdchk("count_three", CSR, 32'd3);
      @(posedge clk);
      #2 rst = 1'b0;
      chk("rst_async_data", 32'h0, 1'b0);
      rst = 1'b1;
      rdchk("rst_count", CSR, 32'h0);
      push(24'h5a5a5a);
      rdchk("post_rst_push", BUF, 32'h005a5a5a);
      rdchk("post_rst_count", CSR, 32'h1);

      repeat (2) tick();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/nkmd_dai_rx.md
NKMD_DAI_RX -- requirements
Module: nkmd_dai_rx

Interface
REQ-001 SHALL have parameter ADDR_CSR, default 32'h0000d001, CPU address of the unread-count register (read) and the consume command (write).
REQ-002 SHALL have parameter ADDR_STAT, default 32'h0000d002, CPU address of the status register.
REQ-003 SHALL have parameter ADDR_BUF, default 32'h0000e000, base CPU address of the 64-word receive window.
REQ-004 SHALL have port clk, input, 1 bit: single clock; all state changes on its rising edge.
REQ-005 SHALL have port rst, input, 1 bit: reset, asynchronous and active-low.
REQ-006 SHALL have port rx_ack_i, input, 1 bit: one-cycle strobe from the DAI receiver; rx_data_i is valid for that cycle.
REQ-007 SHALL have port rx_data_i, input, 24 bits: received sample.
REQ-008 SHALL have port data_i, input, 32 bits: NKMD write data.
REQ-009 SHALL have port data_o, output, 32 bits: NKMD read data, registered.
REQ-010 SHALL have port addr_i, input, 32 bits: NKMD address.
REQ-011 SHALL have port we_i, input, 1 bit: NKMD write enable.
REQ-012 SHALL have port rx_overflow_o, output, 1 bit: sticky overflow flag.

Function
REQ-013 SHALL store samples in a 64-entry x 24-bit ring buffer with 6-bit write pointer wr_ff, 6-bit read pointer rd_ff, and 6-bit unread count unread_ff; usable capacity is 63.
REQ-014 On rx_ack_i with unread_ff < 63, SHALL write rx_data_i at wr_ff, then increment wr_ff (mod 64) and unread_ff.
REQ-015 On rx_ack_i with unread_ff == 63 (full), SHALL drop the sample, leave wr_ff unchanged, and set overflow_ff.
REQ-016 A CPU write (we_i=1) to ADDR_CSR SHALL consume n = min(data_i[5:0], unread_ff) samples: rd_ff += n (mod 64), unread_ff -= n.
REQ-017 If a push and a consume occur in the same cycle, SHALL compute n against the pre-push unread_ff and set unread_ff_next = unread_ff + push - n; the push is accepted unless unread_ff == 63.
REQ-018 A CPU write to ADDR_STAT with data_i[0]=1 SHALL clear overflow_ff, except that a same-cycle dropped push keeps the flag set.
REQ-019 data_o SHALL update one clock after addr_i is presented, as follows:
- ADDR_CSR: {26'b0, unread_ff}
- ADDR_STAT: {31'b0, overflow_ff}
- ADDR_BUF+k (k = 0..63): {8'h0, ring[(rd_ff + k) mod 64]}, i.e. the k-th oldest unread sample
- any other address: 32'h0
REQ-020 Reads SHALL have no side effects; window reads at k >= unread_ff return stale ring contents, not zero.
REQ-021 Writes to ADDR_BUF and to unmapped addresses SHALL be ignored.
REQ-022 rx_overflow_o SHALL equal overflow_ff.
REQ-023 Pointer and count arithmetic SHALL be 6-bit modulo; wrap of wr_ff/rd_ff from 63 to 0 SHALL be seamless.

Reset
REQ-024 While rst=0, SHALL force wr_ff, rd_ff, unread_ff, overflow_ff and data_o to 0, independent of clk; ring contents are not reset.
REQ-025 SHALL ignore rx_ack_i and CPU writes during reset; after rst rises, the first push SHALL land at ring[0].
REQ-026 Reset asserted mid-stream SHALL discard all unread samples, so a subsequent ADDR_CSR read returns 0.

Verification
REQ-027 Reset, then read ADDR_CSR -> data_o = 32'h0; rx_overflow_o = 0.
REQ-028 Push 24'hcafebb, read ADDR_BUF -> 32'h00cafebb; read ADDR_CSR -> 32'h1; write ADDR_CSR with 1, read ADDR_CSR -> 32'h0.
REQ-029 Push 0..62 -> ADDR_CSR reads 63; push 24'h3f -> dropped, rx_overflow_o = 1, ADDR_BUF+62 reads 32'h3e; write ADDR_STAT with 1 -> flag 0.
REQ-030 Consume 63, then push 63..79 -> pointers wrap past 63; ADDR_BUF+k reads 63+k for k = 0..16; write 100 to ADDR_CSR -> consumes exactly 17, count 0.
REQ-031 With count 5, push and write ADDR_CSR with 2 in the same cycle -> count 4, and the pushed sample is at ADDR_BUF+3.
REQ-032 Push 3 samples, pulse rst low between clock edges -> count 0 immediately; next push is readable at ADDR_BUF+0.
